// File: rtl/fcvt_int_pipe.sv
// fcvt_int_pipe: three-stage pipelined int32/uint32 to single/double conversion
// with round-to-nearest-even, fflags and NaN-boxing of single-precision results.
`default_nettype none

module fcvt_int_pipe #(
    parameter int LG_ROB = 6,
    parameter int LG_PRF = 7
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [1:0]        i_op,
    input  logic [63:0]       i_src,
    input  logic [LG_ROB-1:0] i_rob_ptr,
    input  logic [LG_PRF-1:0] i_dst_ptr,
    input  logic              i_flush,
    output logic              o_valid,
    input  logic              i_wb_ready,
    output logic [63:0]       o_data,
    output logic [4:0]        o_fflags,
    output logic [LG_ROB-1:0] o_rob_ptr,
    output logic [LG_PRF-1:0] o_dst_ptr
);

    // A stage may load when it is empty or its content moves on this cycle.
    logic s2_free, s1_free, s0_free;
    logic s0_valid, s1_valid;

    assign s2_free = !o_valid || i_wb_ready;
    assign s1_free = !s1_valid || s2_free;
    assign s0_free = !s0_valid || s1_free;
    assign o_ready = s0_free;

    // S0 inputs: odd ops are unsigned, i_op[1] selects double.
    logic        src_neg;
    logic [31:0] src_mag;

    assign src_neg = !i_op[0] && i_src[31];
    assign src_mag = src_neg ? (~i_src[31:0] + 32'd1) : i_src[31:0];

    logic              s0_dbl, s0_sign;
    logic [31:0]       s0_mag;
    logic [LG_ROB-1:0] s0_rob;
    logic [LG_PRF-1:0] s0_dst;

    // S1 inputs: leading-one position and normalized magnitude.
    logic [4:0]  lead;
    logic [31:0] norm;
    logic        mag_zero;

    always_comb begin
        lead = '0;
        for (int i = 0; i < 32; i++) begin
            if (s0_mag[i]) lead = 5'(i);
        end
    end

    assign norm     = s0_mag << (5'd31 - lead);
    assign mag_zero = ~|s0_mag;

    logic              s1_dbl, s1_sign, s1_zero;
    logic [4:0]        s1_lead;
    logic [31:0]       s1_norm;
    logic [LG_ROB-1:0] s1_rob;
    logic [LG_PRF-1:0] s1_dst;

    // S2 inputs: round and pack. A fraction carry ripples into the exponent field.
    logic        guard, sticky, round_up;
    logic [7:0]  exp_s;
    logic [10:0] exp_d;
    logic [30:0] mag_s;
    logic [31:0] res_s;
    logic [63:0] res_d;
    logic [63:0] next_data;
    logic [4:0]  next_flags;

    assign guard    = s1_norm[7];
    assign sticky   = |s1_norm[6:0];
    assign round_up = guard && (sticky || s1_norm[8]);
    assign exp_s    = 8'd127 + {3'b000, s1_lead};
    assign exp_d    = 11'd1023 + {6'b000000, s1_lead};
    assign mag_s    = {exp_s, s1_norm[30:8]} + {30'd0, round_up};
    assign res_s    = s1_zero ? 32'd0 : {s1_sign, mag_s};
    assign res_d    = s1_zero ? 64'd0 : {s1_sign, exp_d, s1_norm[30:0], 21'd0};

    assign next_data  = s1_dbl ? res_d : {32'hFFFF_FFFF, res_s};
    assign next_flags = s1_dbl ? 5'd0 : {4'd0, guard | sticky};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0_valid  <= 1'b0;
            s0_dbl    <= 1'b0;
            s0_sign   <= 1'b0;
            s0_mag    <= '0;
            s0_rob    <= '0;
            s0_dst    <= '0;
            s1_valid  <= 1'b0;
            s1_dbl    <= 1'b0;
            s1_sign   <= 1'b0;
            s1_zero   <= 1'b0;
            s1_lead   <= '0;
            s1_norm   <= '0;
            s1_rob    <= '0;
            s1_dst    <= '0;
            o_valid   <= 1'b0;
            o_data    <= '0;
            o_fflags  <= '0;
            o_rob_ptr <= '0;
            o_dst_ptr <= '0;
        end else begin
            if (i_flush) begin
                s0_valid <= 1'b0;
                s1_valid <= 1'b0;
                o_valid  <= 1'b0;
            end else begin
                if (s0_free) s0_valid <= i_valid;
                if (s1_free) s1_valid <= s0_valid;
                if (s2_free) o_valid  <= s1_valid;
            end

            if (s0_free) begin
                s0_dbl  <= i_op[1];
                s0_sign <= src_neg;
                s0_mag  <= src_mag;
                s0_rob  <= i_rob_ptr;
                s0_dst  <= i_dst_ptr;
            end

            if (s1_free) begin
                s1_dbl  <= s0_dbl;
                s1_sign <= s0_sign;
                s1_zero <= mag_zero;
                s1_lead <= lead;
                s1_norm <= norm;
                s1_rob  <= s0_rob;
                s1_dst  <= s0_dst;
            end

            if (s2_free) begin
                o_data    <= next_data;
                o_fflags  <= next_flags;
                o_rob_ptr <= s1_rob;
                o_dst_ptr <= s1_dst;
            end
        end
    end

    // Upper source half and the implicit one are architecturally ignored.
    logic unused_bits;
    assign unused_bits = ^{i_src[63:32], s1_norm[31]};

endmodule

`default_nettype wire

// File: tb/tb_fcvt_int_pipe.sv
// tb_fcvt_int_pipe: directed-vector self-checking bench for fcvt_int_pipe.
`default_nettype none

module tb_fcvt_int_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_valid;
    logic        o_ready;
    logic [1:0]  i_op;
    logic [63:0] i_src;
    logic [5:0]  i_rob_ptr;
    logic [6:0]  i_dst_ptr;
    logic        i_flush;
    logic        o_valid;
    logic        i_wb_ready;
    logic [63:0] o_data;
    logic [4:0]  o_fflags;
    logic [5:0]  o_rob_ptr;
    logic [6:0]  o_dst_ptr;

    fcvt_int_pipe #(.LG_ROB(6), .LG_PRF(7)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_op       (i_op),
        .i_src      (i_src),
        .i_rob_ptr  (i_rob_ptr),
        .i_dst_ptr  (i_dst_ptr),
        .i_flush    (i_flush),
        .o_valid    (o_valid),
        .i_wb_ready (i_wb_ready),
        .o_data     (o_data),
        .o_fflags   (o_fflags),
        .o_rob_ptr  (o_rob_ptr),
        .o_dst_ptr  (o_dst_ptr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    logic chk_lat;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [63:0] data;
        logic [4:0]  flags;
        logic [5:0]  rob;
        logic [6:0]  dst;
        int          acc;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic [63:0] exp_data;
    logic [4:0]  exp_flags;

    // Scoreboard: retire on transfer, drop on flush/reset, enqueue on accept.
    always @(negedge clk) begin
        if (!reset_n) begin
            q.delete();
        end else begin
            if (o_valid && i_wb_ready) begin
                if (q.size() == 0) begin
                    check("spurious_result", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    check("data", o_data, e.data);
                    check("fflags", 64'(o_fflags), 64'(e.flags));
                    check("rob_tag", 64'(o_rob_ptr), 64'(e.rob));
                    check("dst_tag", 64'(o_dst_ptr), 64'(e.dst));
                    if (chk_lat) check("latency", 64'(cycle - e.acc), 64'd3);
                end
            end
            if (i_flush) begin
                q.delete();
            end else if (i_valid && o_ready) begin
                e.data  = exp_data;
                e.flags = exp_flags;
                e.rob   = i_rob_ptr;
                e.dst   = i_dst_ptr;
                e.acc   = cycle;
                q.push_back(e);
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [63:0] src, input logic [5:0] rob,
                         input logic [6:0] dst, input logic [63:0] xd, input logic [4:0] xf);
        int   n  = 0;
        logic ok = 1'b0;
        i_valid   = 1'b1;
        i_op      = op;
        i_src     = src;
        i_rob_ptr = rob;
        i_dst_ptr = dst;
        exp_data  = xd;
        exp_flags = xf;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = o_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) check("issue_timeout", 64'd0, 64'd1);
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("drain_empty", 64'(q.size()), 64'd0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n    = 1'b0;
        i_valid    = 1'b0;
        i_op       = 2'd0;
        i_src      = 64'd0;
        i_rob_ptr  = 6'd0;
        i_dst_ptr  = 7'd0;
        i_flush    = 1'b0;
        i_wb_ready = 1'b1;
        chk_lat    = 1'b1;
        exp_data   = 64'd0;
        exp_flags  = 5'd0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_o_valid", 64'(o_valid), 64'd0);
        check("reset_o_data", o_data, 64'd0);
        check("reset_o_fflags", 64'(o_fflags), 64'd0);
        check("reset_o_rob", 64'(o_rob_ptr), 64'd0);
        check("reset_o_dst", 64'(o_dst_ptr), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_o_ready", 64'(o_ready), 64'd1);
        @(posedge clk);
        #1;

        // Basic single precision, back-to-back.
        issue(2'd0, 64'h0000_0000_0000_0001, 6'd1, 7'd1, 64'hFFFFFFFF_3F800000, 5'd0);
        issue(2'd0, 64'h0000_0000_FFFF_FFFF, 6'd2, 7'd2, 64'hFFFFFFFF_BF800000, 5'd0);
        issue(2'd0, 64'h0000_0000_0000_0000, 6'd3, 7'd3, 64'hFFFFFFFF_00000000, 5'd0);
        drain();

        // Rounding.
        issue(2'd0, 64'h0000_0000_7FFF_FFFF, 6'd4, 7'd4, 64'hFFFFFFFF_4F000000, 5'd1);
        issue(2'd0, 64'h0000_0000_0100_0001, 6'd5, 7'd5, 64'hFFFFFFFF_4B800000, 5'd1);
        issue(2'd0, 64'h0000_0000_0100_0003, 6'd6, 7'd6, 64'hFFFFFFFF_4B800002, 5'd1);
        drain();

        // Unsigned and double precision; upper source half must be ignored.
        issue(2'd1, 64'hDEADBEEF_FFFF_FFFF, 6'd7, 7'd7, 64'hFFFFFFFF_4F800000, 5'd1);
        issue(2'd2, 64'hDEADBEEF_8000_0000, 6'd8, 7'd8, 64'hC1E00000_00000000, 5'd0);
        issue(2'd3, 64'hDEADBEEF_8000_0000, 6'd9, 7'd9, 64'h41E00000_00000000, 5'd0);
        issue(2'd2, 64'hDEADBEEF_7FFF_FFFF, 6'd10, 7'd10, 64'h41DFFFFF_FFC00000, 5'd0);
        drain();

        // Backpressure: stall writeback for 5 cycles once the first result shows.
        chk_lat = 1'b0;
        fork
            begin
                issue(2'd0, 64'h1, 6'd11, 7'd11, 64'hFFFFFFFF_3F800000, 5'd0);
                issue(2'd0, 64'hFFFF_FFFF, 6'd12, 7'd12, 64'hFFFFFFFF_BF800000, 5'd0);
                issue(2'd0, 64'h7FFF_FFFF, 6'd13, 7'd13, 64'hFFFFFFFF_4F000000, 5'd1);
                issue(2'd3, 64'h8000_0000, 6'd14, 7'd14, 64'h41E00000_00000000, 5'd0);
            end
            begin
                int n = 0;
                while (!o_valid && n < 20) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                check("bp_first_valid", 64'(o_valid), 64'd1);
                i_wb_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("bp_hold_valid", 64'(o_valid), 64'd1);
                    check("bp_hold_data", o_data, 64'hFFFFFFFF_3F800000);
                    check("bp_hold_rob", 64'(o_rob_ptr), 64'd11);
                    check("bp_o_ready", 64'(o_ready), 64'd0);
                    @(posedge clk);
                    #1;
                end
                i_wb_ready = 1'b1;
            end
        join
        drain();
        chk_lat = 1'b1;

        // Flush with three in flight; the head transfers in the flush cycle.
        issue(2'd0, 64'h1, 6'd20, 7'd20, 64'hFFFFFFFF_3F800000, 5'd0);
        issue(2'd0, 64'h3, 6'd21, 7'd21, 64'hFFFFFFFF_40400000, 5'd0);
        issue(2'd0, 64'h4, 6'd22, 7'd22, 64'hFFFFFFFF_40800000, 5'd0);
        i_valid   = 1'b1;
        i_op      = 2'd0;
        i_src     = 64'h5;
        i_rob_ptr = 6'd30;
        i_dst_ptr = 7'd30;
        i_flush   = 1'b1;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        check("flush_o_valid", 64'(o_valid), 64'd0);
        issue(2'd0, 64'h2, 6'd31, 7'd33, 64'hFFFFFFFF_40000000, 5'd0);
        drain();

        // Asynchronous reset while a result is on the output.
        issue(2'd0, 64'h1, 6'd40, 7'd40, 64'hFFFFFFFF_3F800000, 5'd0);
        issue(2'd0, 64'h3, 6'd41, 7'd41, 64'hFFFFFFFF_40400000, 5'd0);
        issue(2'd0, 64'h4, 6'd42, 7'd42, 64'hFFFFFFFF_40800000, 5'd0);
        check("rst_pre_valid", 64'(o_valid), 64'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_async_valid", 64'(o_valid), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_o_ready", 64'(o_ready), 64'd1);
        check("rst_o_data", o_data, 64'd0);
        repeat (8) @(posedge clk);
        #1;
        check("rst_no_stale", 64'(o_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fcvt_int_pipe.md
Name: fcvt_int_pipe

Overview:
- Pipelined integer-to-floating-point conversion unit for FCVT.S.W, FCVT.S.WU, FCVT.D.W and FCVT.D.WU.
- Sits between the FP scheduler issue port and the FP writeback arbiter.
- Accepts a 64-bit source register value with ROB/PRF tags and selects/extends the 32-bit operand.
- Normalizes, rounds to nearest-even, sets fflags, and returns a tagged, NaN-boxed result to writeback.

Parameters:
- LG_ROB, 6, log2 of ROB entries; width of the ROB pointer tag.
- LG_PRF, 7, log2 of physical FP registers; width of the destination tag.

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous active-low reset.
- i_valid  input  1  request valid.
- o_ready  output  1  unit can accept a request this cycle.
- i_op  input  2  0=W->S, 1=WU->S, 2=W->D, 3=WU->D.
- i_src  input  64  integer source; only bits [31:0] are used.
- i_rob_ptr  input  LG_ROB  ROB tag.
- i_dst_ptr  input  LG_PRF  destination physical register.
- i_flush  input  1  pipeline kill (mispredict/exception).
- o_valid  output  1  result valid.
- i_wb_ready  input  1  writeback accepts the result.
- o_data  output  64  result; single-precision results are NaN-boxed (upper 32 bits all ones).
- o_fflags  output  5  {NV,DZ,OF,UF,NX}; only NX can be set.
- o_rob_ptr  output  LG_ROB  tag passthrough.
- o_dst_ptr  output  LG_PRF  tag passthrough.

Behaviour:
- Reset: on reset_n low, all stage valids clear immediately. o_valid=0, o_data=0, o_fflags=0, tags=0, o_ready=1 after reset release.
- Pipeline: three registered stages (S0, S1, S2).
  - S0 captures the operand, sign and magnitude. Signed ops take the two's complement of negative values. 0x80000000 has magnitude 2^31.
  - S1 does leading-one detect and left-normalizes the magnitude into a 32-bit field with the implicit one at bit 31.
  - S2 rounds, packs and drives the outputs.
- Latency: a request accepted in cycle N presents o_valid in cycle N+3 when there is no stall. Throughput is one per cycle.
- Handshake:
  - Accept occurs when i_valid && o_ready && !i_flush.
  - Output transfers when o_valid && i_wb_ready.
  - When o_valid && !i_wb_ready, all stages hold. o_data, o_fflags and tags stay stable.
  - Holding occupied stages still allows bubbles to collapse: a stage advances if the next stage is empty or advancing.
  - o_ready = !S0_valid || S0_advances. o_ready is combinational from i_wb_ready.
- Exponent: single uses bias 127, 8-bit exponent, 23-bit fraction. Double uses bias 1023, 11-bit exponent, 52-bit fraction. exp = bias + (index of leading one).
- Rounding is round-to-nearest-even:
  - Guard = first dropped bit; sticky = OR of the remaining dropped bits.
  - Increment when guard && (sticky || lsb).
  - A mantissa carry-out increments the exponent and zeroes the fraction.
  - No overflow is possible.
  - NX = guard || sticky.
  - Double results are always exact (NX=0).
- Zero input: result +0.0 with NX=0. For single ops the result is NaN-boxed, i.e. 0xFFFFFFFF00000000.
- Sign: unsigned ops always produce positive results.
- Flush:
  - i_flush clears S0/S1/S2 valids in the same clock edge.
  - A request presented together with i_flush is dropped.
  - o_valid is 0 the cycle after a flush.
  - A result that transfers in the flush cycle (o_valid && i_wb_ready) counts as delivered.
- Reset mid-operation: in-flight entries are discarded with no output.

Test Plan:
- Single precision, in order, back-to-back with i_wb_ready=1:
  - W->S of 1 -> o_data 0xFFFFFFFF3F800000, NX=0.
  - W->S of 0xFFFFFFFF -> 0xFFFFFFFFBF800000.
  - W->S of 0 -> 0xFFFFFFFF00000000.
  - Check o_valid exactly 3 cycles after each accept.
- Rounding, single precision:
  - W->S of 0x7FFFFFFF -> 0xFFFFFFFF4F000000, NX=1 (carry into exponent).
  - W->S of 0x01000001 -> 0xFFFFFFFF4B800000, NX=1 (tie to even).
  - W->S of 0x01000003 -> 0xFFFFFFFF4B800002, NX=1.
- Unsigned and double precision:
  - WU->S of 0xFFFFFFFF -> 0xFFFFFFFF4F800000, NX=1.
  - W->D of 0x80000000 -> 0xC1E0000000000000, NX=0.
  - WU->D of 0x80000000 -> 0x41E0000000000000.
  - i_src[63:32]=0xDEADBEEF is ignored.
- Backpressure:
  - Issue 4 back-to-back requests; drop i_wb_ready for 5 cycles once the first result appears.
  - o_data and tags must hold and o_ready=0 while the pipe is full.
  - Results must drain in order with no loss or duplication.
- Flush:
  - With 3 entries in flight, pulse i_flush together with a new i_valid.
  - No results may emerge afterward.
  - A request issued the next cycle must appear 3 cycles later with the correct tags.
- Async reset:
  - Assert reset_n low mid-stream between clock edges.
  - o_valid must drop immediately (before the next clock edge).
  - After release, o_ready=1 and no stale results appear.
